// File: rtl/cmp_word_sequencer_if.sv
// Bus bundle between the compare-slice word sequencer and its environment.
// The abort signal exists only when SEQ_ABORT_EN is defined.
interface cmp_word_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 2
);
    logic             wr_en;
    logic [SEL_W-1:0] wr_bank;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             start_carry;
    logic             hold;
    logic             cmp_result;
`ifdef SEQ_ABORT_EN
    logic             abort;
`endif
    logic [WIDTH-1:0] op_word;
    logic [SEL_W-1:0] bank_sel;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic             final_result;

`ifdef SEQ_ABORT_EN
    modport master (
        output wr_en, wr_bank, wr_data, start, start_carry, hold, cmp_result, abort,
        input  op_word, bank_sel, carry_in, busy, done, final_result
    );
    modport slave (
        input  wr_en, wr_bank, wr_data, start, start_carry, hold, cmp_result, abort,
        output op_word, bank_sel, carry_in, busy, done, final_result
    );
`else
    modport master (
        output wr_en, wr_bank, wr_data, start, start_carry, hold, cmp_result,
        input  op_word, bank_sel, carry_in, busy, done, final_result
    );
    modport slave (
        input  wr_en, wr_bank, wr_data, start, start_carry, hold, cmp_result,
        output op_word, bank_sel, carry_in, busy, done, final_result
    );
`endif
endinterface

// File: rtl/cmp_word_sequencer.sv
// Feeds NBANK operand words to the compare slice, chaining its result as carry.
// Optional SEQ_ABORT_EN adds an abort input that cancels a scan in progress.
module cmp_word_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NBANK = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cmp_word_sequencer_if.slave   bus
);
    localparam int unsigned LAST = NBANK - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             carry_q, carry_d;
    logic             final_q, final_d;
    logic [WIDTH-1:0] bank_q [NBANK];

    // Operand bank: writes land in any state; reset clears every word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NBANK); i++) begin
                bank_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            bank_q[bus.wr_bank] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            carry_q <= 1'b0;
            final_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            final_q <= final_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        final_d = final_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SCAN;
                    sel_d   = '0;
                    carry_d = bus.start_carry;
                end
            end
            S_SCAN: begin
`ifdef SEQ_ABORT_EN
                if (bus.abort) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    carry_d = 1'b0;
                end else
`endif
                if (!bus.hold) begin
                    carry_d = bus.cmp_result;
                    if (sel_q != SEL_W'(LAST)) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        final_d = bus.cmp_result;
                        sel_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decode straight from the state register.
    assign bus.op_word      = bank_q[sel_q];
    assign bus.bank_sel     = sel_q;
    assign bus.carry_in     = carry_q;
    assign bus.busy         = (state_q == S_SCAN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.final_result = final_q;
endmodule

// File: tb/tb_cmp_word_sequencer.sv
// Bench for cmp_word_sequencer: directed vector table, hand sequences and a
// randomized run checked against a behavioural model.
module tb_cmp_word_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NBANK = 4;
    localparam int unsigned SEL_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cmp_word_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    cmp_word_sequencer #(.WIDTH(WIDTH), .NBANK(NBANK), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [1:0] wr_bank;
        logic [7:0] wr_data;
        logic       start;
        logic       sc;
        logic       hold;
        logic       cmp;
        logic [7:0] op;
        logic [1:0] sel;
        logic       carry;
        logic       busy;
        logic       done;
        logic       fin;
    } vec_t;

    // Behavioural model: a scan is "position m_idx of NBANK words".
    logic [7:0] m_bank [NBANK];
    bit         m_scan, m_done, m_carry, m_final;
    int         m_idx;

    function automatic vec_t mk(logic r, logic we, logic [1:0] wb, logic [7:0] wd,
                                logic st, logic sc, logic h, logic c,
                                logic [7:0] op, logic [1:0] sel, logic car,
                                logic bsy, logic dn, logic fn);
        vec_t v;
        v.rst = r; v.wr_en = we; v.wr_bank = wb; v.wr_data = wd;
        v.start = st; v.sc = sc; v.hold = h; v.cmp = c;
        v.op = op; v.sel = sel; v.carry = car; v.busy = bsy; v.done = dn; v.fin = fn;
        return v;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.start_carry = 1'b0; bus.hold = 1'b0; bus.cmp_result = 1'b0;
`ifdef SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    function automatic logic model_abort();
`ifdef SEQ_ABORT_EN
        return bus.abort;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        logic ab;
        ab = model_abort();
        if (rst) begin
            for (int i = 0; i < int'(NBANK); i++) m_bank[i] = 8'h00;
            m_scan = 0; m_done = 0; m_carry = 0; m_final = 0; m_idx = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (!m_scan) begin
                if (bus.start) begin
                    m_scan = 1; m_idx = 0; m_carry = bus.start_carry;
                end
            end else if (ab) begin
                m_scan = 0; m_idx = 0; m_carry = 0;
            end else if (!bus.hold) begin
                m_carry = bus.cmp_result;
                if (m_idx == int'(NBANK) - 1) begin
                    m_final = bus.cmp_result; m_idx = 0; m_scan = 0; m_done = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
            if (bus.wr_en) m_bank[bus.wr_bank] = bus.wr_data;
        end
    endtask

    function automatic logic [13:0] model_exp();
        return {m_bank[m_idx], 2'(m_idx), m_carry, m_scan, m_done, m_final};
    endfunction

    // One clock: advance the model with the inputs the DUT sees, then settle.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [13:0] exp);
        logic [13:0] got;
        got = {bus.op_word, bus.bank_sel, bus.carry_in, bus.busy, bus.done, bus.final_result};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got op=%h sel=%0d carry=%b busy=%b done=%b final=%b, expected op=%h sel=%0d carry=%b busy=%b done=%b final=%b",
                     name, got[13:6], got[5:4], got[3], got[2], got[1], got[0],
                     exp[13:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    vec_t tbl [23];

    initial begin
        //           rst we wb  wd     st sc h  c   op     sel car bsy dn fn
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8'h11, 0, 0, 0, 0, 8'h11, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 8'h22, 0, 0, 0, 0, 8'h11, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 2, 8'h33, 0, 0, 0, 0, 8'h11, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 3, 8'h44, 0, 0, 0, 0, 8'h11, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h11, 0, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h22, 1, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 8'h33, 2, 1, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 8'h44, 3, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h11, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h11, 0, 0, 0, 0, 0);
        // second scan: start while busy, two hold cycles at bank 2, start in DONE
        tbl[11] = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h11, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 8'h22, 1, 1, 1, 0, 0);
        tbl[13] = mk(0, 1, 3, 8'h5C, 1, 0, 0, 1, 8'h33, 2, 1, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h33, 2, 1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h33, 2, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h5C, 3, 0, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h11, 0, 1, 0, 1, 1);
        tbl[18] = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h11, 0, 1, 0, 0, 1);
        // restart, write the selected bank while held, then reset mid-scan
        tbl[19] = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h11, 0, 0, 1, 0, 1);
        tbl[20] = mk(0, 1, 0, 8'hA5, 0, 0, 1, 0, 8'hA5, 0, 0, 1, 0, 1);
        tbl[21] = mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

        idle_inputs();
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst;
            bus.wr_en = tbl[i].wr_en; bus.wr_bank = tbl[i].wr_bank; bus.wr_data = tbl[i].wr_data;
            bus.start = tbl[i].start; bus.start_carry = tbl[i].sc;
            bus.hold = tbl[i].hold; bus.cmp_result = tbl[i].cmp;
            cycle();
            check($sformatf("table[%0d]", i),
                  {tbl[i].op, tbl[i].sel, tbl[i].carry, tbl[i].busy, tbl[i].done, tbl[i].fin});
        end
        idle_inputs();

        // Reset mid-scan at bank 2: no done pulse follows, final stays 0.
        bus.start = 1'b1; bus.start_carry = 1'b1; cycle(); idle_inputs();
        bus.cmp_result = 1'b1; cycle(); cycle();
        check("midscan_at_sel2", {8'h00, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        idle_inputs(); rst = 1'b1; bus.cmp_result = 1'b1; cycle(); idle_inputs();
        check("midscan_reset", 14'h0);

        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("idle_after_reset[%0d]", i), 14'h0);
        end

`ifdef SEQ_ABORT_EN
        // Complete a scan with result 1, then abort (with hold) at bank 1.
        bus.start = 1'b1; cycle(); idle_inputs();
        bus.cmp_result = 1'b1;
        for (int i = 0; i < int'(NBANK); i++) cycle();
        idle_inputs();
        check("abort_prior_done", {8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1});
        cycle();
        bus.start = 1'b1; cycle(); idle_inputs();
        bus.cmp_result = 1'b1; cycle(); idle_inputs();
        check("abort_at_sel1", {8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1});
        bus.abort = 1'b1; bus.hold = 1'b1; cycle(); idle_inputs();
        check("abort_idle", {8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        cycle();
        check("abort_no_done", {8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
`endif

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.wr_bank = 2'($urandom_range(0, 3));
            bus.wr_data = 8'($urandom);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.start_carry = 1'($urandom);
            bus.hold = ($urandom_range(0, 3) == 0);
            bus.cmp_result = 1'($urandom);
`ifdef SEQ_ABORT_EN
            bus.abort = ($urandom_range(0, 15) == 0);
`endif
            cycle();
            check($sformatf("random[%0d]", n), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
